// File: rtl/sr_chain_driver.sv
// Serial driver for a daisy-chained 74HC595-class shift-register string.
// Shifts a WIDTH-bit word out at a divided rate, then pulses the latch.
module sr_chain_driver #(
  parameter int WIDTH       = 8,
  parameter int CLK_DIV     = 1,
  parameter bit MSB_FIRST   = 1'b0,
  parameter bit AUTO_UPDATE = 1'b1
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             shift,
  output logic             latch,
  output logic             data
);

  localparam int BW = $clog2(WIDTH);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    CLOCK,
    LATCH
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BW-1:0]    bit_nxt;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] last_sent_q, last_sent_d;
  logic [WIDTH-1:0] shadow_ord;
  logic             shift_q, shift_d;
  logic             latch_q, latch_d;
  logic             data_q, data_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             tick;
  logic             start;
  logic             first_bit;

  // Transmission order, so bit_cnt always indexes the next bit to send
  always_comb begin
    shadow_ord = '0;
    for (int i = 0; i < WIDTH; i++) begin
      shadow_ord[i] = MSB_FIRST ? shadow_q[WIDTH-1-i] : shadow_q[i];
    end
  end

  assign tick      = (div_cnt_q == DIV_LAST);
  assign bit_nxt   = bit_cnt_q + 1'b1;
  assign first_bit = MSB_FIRST ? din[WIDTH-1] : din[0];
  assign start     = load || (AUTO_UPDATE && (din != last_sent_q));

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shadow_d    = shadow_q;
    last_sent_d = last_sent_q;
    shift_d     = shift_q;
    latch_d     = latch_q;
    data_d      = data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d  = din;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          data_d    = first_bit;
          shift_d   = 1'b0;
          busy_d    = 1'b1;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          div_cnt_d = '0;
          shift_d   = 1'b1;
          state_d   = CLOCK;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      CLOCK: begin
        if (tick) begin
          div_cnt_d = '0;
          shift_d   = 1'b0;
          if (bit_cnt_q == BIT_LAST) begin
            latch_d = 1'b1;
            done_d  = (CLK_DIV == 1);
            state_d = LATCH;
          end else begin
            bit_cnt_d = bit_nxt;
            data_d    = shadow_ord[bit_nxt];
            state_d   = SETUP;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      LATCH: begin
        if (tick) begin
          div_cnt_d   = '0;
          latch_d     = 1'b0;
          last_sent_d = shadow_q;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
          done_d    = ((div_cnt_q + 1'b1) == DIV_LAST);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      div_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shadow_q    <= '0;
      last_sent_q <= '1;
      shift_q     <= 1'b0;
      latch_q     <= 1'b0;
      data_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shadow_q    <= shadow_d;
      last_sent_q <= last_sent_d;
      shift_q     <= shift_d;
      latch_q     <= latch_d;
      data_q      <= data_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign ready = ~busy_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign shift = shift_q;
  assign latch = latch_q;
  assign data  = data_q;

endmodule
